// File: rtl/proc_pkg.sv
// proc_pkg: shared types and constants for the processor front end.
//   - fetchState_t : instruction fetch control states
//   - OP_*         : opcode encodings carried in instruction bits [8:6]
//   - *_MSB/*_LSB  : field positions in the 9-bit instruction word
//   - opField/destField/srcField : field extraction helpers
package proc_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    ISSUE  = 2'd2,
    HALTED = 2'd3
  } fetchState_t;

  localparam logic [2:0] OP_LOAD  = 3'b000;
  localparam logic [2:0] OP_MOVE  = 3'b001;
  localparam logic [2:0] OP_ADD   = 3'b010;
  localparam logic [2:0] OP_SUB   = 3'b011;
  localparam logic [2:0] OP_AND   = 3'b100;
  localparam logic [2:0] OP_OR    = 3'b101;
  localparam logic [2:0] OP_XOR   = 3'b110;
  localparam logic [2:0] OP_STORE = 3'b111;

  localparam int INSTR_LEN  = 9;
  localparam int OPCODE_MSB = 8;
  localparam int OPCODE_LSB = 6;
  localparam int DEST_MSB   = 5;
  localparam int DEST_LSB   = 3;
  localparam int SRC_MSB    = 2;
  localparam int SRC_LSB    = 0;

  function automatic logic [2:0] opField(input logic [INSTR_LEN-1:0] instr);
    return instr[OPCODE_MSB:OPCODE_LSB];
  endfunction

  function automatic logic [2:0] destField(input logic [INSTR_LEN-1:0] instr);
    return instr[DEST_MSB:DEST_LSB];
  endfunction

  function automatic logic [2:0] srcField(input logic [INSTR_LEN-1:0] instr);
    return instr[SRC_MSB:SRC_LSB];
  endfunction

endpackage

// File: rtl/instruction_fetch_pc_reg.sv
// pc_reg: program counter with clear, increment and jump load, plus the
// end-of-program test on the candidate next value.
//   clk, rst_n : clock, asynchronous active-low reset
//   clear      : force PC to 0 (start of a program run)
//   advance    : instruction accepted; PC takes the candidate next value
//   jumpEn     : candidate is jumpAddr instead of pc+1
//   jumpAddr   : jump target
//   pc         : current program counter
//   endOfProg  : candidate next value is at or beyond PROG_LEN
module pc_reg #(
  parameter int ADDR_W   = 5,
  parameter int PROG_LEN = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              advance,
  input  logic              jumpEn,
  input  logic [ADDR_W-1:0] jumpAddr,
  output logic [ADDR_W-1:0] pc,
  output logic              endOfProg
);

  // PROG_LEN may equal 2^ADDR_W, so the limit needs one extra bit.
  localparam logic [ADDR_W:0] PROG_END = (ADDR_W+1)'(PROG_LEN);

  logic [ADDR_W-1:0] pc_r;
  logic [ADDR_W:0]   target_s;

  // Candidate next PC, one bit wider so the carry out of pc+1 reaches the limit test.
  always_comb begin
    target_s = {1'b0, pc_r};
    if (jumpEn) begin
      target_s = {1'b0, jumpAddr};
    end else begin
      target_s = {1'b0, pc_r} + {{ADDR_W{1'b0}}, 1'b1};
    end
  end

  assign endOfProg = (target_s >= PROG_END);

  // PC register: cleared on start, stepped or redirected on an accepted instruction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_r <= {ADDR_W{1'b0}};
    end else if (clear) begin
      pc_r <= {ADDR_W{1'b0}};
    end else if (advance) begin
      pc_r <= target_s[ADDR_W-1:0];
    end else begin
      pc_r <= pc_r;
    end
  end

  assign pc = pc_r;

endmodule

// File: rtl/instruction_fetch.sv
// instruction_fetch: fetches instruction words, holds them in the instruction
// register and hands opCode/destReg/srcReg to decode with a valid/ready handshake.
//   clk, rst_n          : clock, asynchronous active-low reset
//   start               : begin fetching at address 0 (from IDLE or HALTED)
//   imemReq/imemAddr    : read request and address (address is the PC)
//   imemValid/imemData  : read response
//   instrValid/instrReady : instruction handshake with decode
//   opCode/destReg/srcReg : fields of the held instruction
//   jumpEn/jumpAddr     : PC redirect, honoured only on the accept cycle
//   pc                  : current program counter
//   halted              : fetch stopped at end of program
module instruction_fetch
  import proc_pkg::*;
#(
  parameter int ADDR_W   = 5,
  parameter int INSTR_W  = 9,
  parameter int PROG_LEN = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  output logic               imemReq,
  output logic [ADDR_W-1:0]  imemAddr,
  input  logic               imemValid,
  input  logic [INSTR_W-1:0] imemData,
  output logic               instrValid,
  input  logic               instrReady,
  output logic [2:0]         opCode,
  output logic [2:0]         destReg,
  output logic [2:0]         srcReg,
  input  logic               jumpEn,
  input  logic [ADDR_W-1:0]  jumpAddr,
  output logic [ADDR_W-1:0]  pc,
  output logic               halted
);

  fetchState_t        state_r;
  fetchState_t        nextState_s;
  logic [INSTR_W-1:0] instrReg_r;
  logic               imemReq_r;
  logic               instrValid_r;
  logic               halted_r;
  logic               pcClear_s;
  logic               pcAdvance_s;
  logic               loadInstr_s;
  logic               endOfProg_s;
  logic [ADDR_W-1:0]  pc_s;

  pc_reg #(
    .ADDR_W   (ADDR_W),
    .PROG_LEN (PROG_LEN)
  ) u_pcReg (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (pcClear_s),
    .advance   (pcAdvance_s),
    .jumpEn    (jumpEn),
    .jumpAddr  (jumpAddr),
    .pc        (pc_s),
    .endOfProg (endOfProg_s)
  );

  // Next-state decode; start is only honoured from IDLE and HALTED.
  always_comb begin
    nextState_s = state_r;
    pcClear_s   = 1'b0;
    pcAdvance_s = 1'b0;
    loadInstr_s = 1'b0;
    case (state_r)
      IDLE, HALTED: begin
        if (start) begin
          nextState_s = FETCH;
          pcClear_s   = 1'b1;
        end else begin
          nextState_s = state_r;
        end
      end
      FETCH: begin
        if (imemValid) begin
          nextState_s = ISSUE;
          loadInstr_s = 1'b1;
        end else begin
          nextState_s = FETCH;
        end
      end
      ISSUE: begin
        // imemValid is deliberately not looked at here: a stray response cannot disturb the held word.
        if (instrValid_r && instrReady) begin
          pcAdvance_s = 1'b1;
          if (endOfProg_s) begin
            nextState_s = HALTED;
          end else begin
            nextState_s = FETCH;
          end
        end else begin
          nextState_s = ISSUE;
        end
      end
      default: begin
        nextState_s = IDLE;
      end
    endcase
  end

  // State register; the handshake outputs are registered copies of the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      imemReq_r    <= 1'b0;
      instrValid_r <= 1'b0;
      halted_r     <= 1'b0;
    end else begin
      state_r      <= nextState_s;
      imemReq_r    <= (nextState_s == FETCH);
      instrValid_r <= (nextState_s == ISSUE);
      halted_r     <= (nextState_s == HALTED);
    end
  end

  // Instruction register: captures the memory word only on the returning read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instrReg_r <= {INSTR_W{1'b0}};
    end else if (loadInstr_s) begin
      instrReg_r <= imemData;
    end else begin
      instrReg_r <= instrReg_r;
    end
  end

  assign imemReq    = imemReq_r;
  assign imemAddr   = pc_s;
  assign pc         = pc_s;
  assign instrValid = instrValid_r;
  assign halted     = halted_r;
  assign opCode     = opField(instrReg_r);
  assign destReg    = destField(instrReg_r);
  assign srcReg     = srcField(instrReg_r);

endmodule

// File: tb/tb_instruction_fetch.sv
module tb_instruction_fetch;

  localparam int AW  = 5;
  localparam int PL  = 12;
  localparam int WAW = 3;
  localparam int WPL = 8;

  typedef struct {
    bit         isHalt;
    int         pcv;
    logic [8:0] ins;
  } exp_t;

  // main instance
  logic          clk;
  logic          rst_n;
  logic          start;
  logic          imemReq;
  logic [AW-1:0] imemAddr;
  logic          imemValid;
  logic [8:0]    imemData;
  logic          instrValid;
  logic          instrReady;
  logic [2:0]    opCode;
  logic [2:0]    destReg;
  logic [2:0]    srcReg;
  logic          jumpEn;
  logic [AW-1:0] jumpAddr;
  logic [AW-1:0] pc;
  logic          halted;

  // wrap instance (ADDR_W=3, PROG_LEN=8) and single-instruction instance
  logic           wStart, tieOne, tieZero;
  logic           wReq, wValid, wIV, wHalted;
  logic [WAW-1:0] wAddr, wPc, wJumpAddr;
  logic [8:0]     wData;
  logic [2:0]     wOp, wDest, wSrc;
  logic           oReq, oValid, oIV, oHalted;
  logic [AW-1:0]  oAddr, oPc, oJumpAddr;
  logic [8:0]     oData;
  logic [2:0]     oOp, oDest, oSrc;

  logic [8:0] mem [32];
  exp_t       q[$];
  exp_t       hd;
  int         compared;
  int         mismatched;
  int         memLat;
  int         reqCnt;
  bit         spurious;
  bit         forceLate;
  bit         scbOn;
  logic       monAcc;
  int         haltPcModel;

  instruction_fetch #(.ADDR_W(AW), .INSTR_W(9), .PROG_LEN(PL)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .imemReq(imemReq), .imemAddr(imemAddr),
    .imemValid(imemValid), .imemData(imemData), .instrValid(instrValid), .instrReady(instrReady),
    .opCode(opCode), .destReg(destReg), .srcReg(srcReg), .jumpEn(jumpEn), .jumpAddr(jumpAddr),
    .pc(pc), .halted(halted)
  );

  instruction_fetch #(.ADDR_W(WAW), .INSTR_W(9), .PROG_LEN(WPL)) dutWrap (
    .clk(clk), .rst_n(rst_n), .start(wStart), .imemReq(wReq), .imemAddr(wAddr),
    .imemValid(wValid), .imemData(wData), .instrValid(wIV), .instrReady(tieOne),
    .opCode(wOp), .destReg(wDest), .srcReg(wSrc), .jumpEn(tieZero), .jumpAddr(wJumpAddr),
    .pc(wPc), .halted(wHalted)
  );

  instruction_fetch #(.ADDR_W(AW), .INSTR_W(9), .PROG_LEN(1)) dutOne (
    .clk(clk), .rst_n(rst_n), .start(wStart), .imemReq(oReq), .imemAddr(oAddr),
    .imemValid(oValid), .imemData(oData), .instrValid(oIV), .instrReady(tieOne),
    .opCode(oOp), .destReg(oDest), .srcReg(oSrc), .jumpEn(tieZero), .jumpAddr(oJumpAddr),
    .pc(oPc), .halted(oHalted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Memory models: main memory answers after memLat cycles of request; the small instances answer at once.
  always @(negedge clk) begin
    if (imemReq) begin
      reqCnt++;
      imemValid = (reqCnt >= memLat);
      imemData  = imemValid ? mem[imemAddr] : 9'($urandom);
    end else begin
      reqCnt    = 0;
      imemValid = forceLate || (spurious && ($urandom_range(0, 3) == 0));
      imemData  = 9'($urandom);
    end
    wValid = wReq;
    wData  = 9'($urandom);
    oValid = oReq;
    oData  = 9'($urandom);
  end

  // Monitor: compares presented instruction, PC, fetch address and halt against the scoreboard.
  always @(posedge clk) begin
    monAcc = rst_n && instrValid && instrReady;
    #1;
    if (scbOn && rst_n) begin
      if (monAcc) begin
        if (q.size() == 0) chk("acceptExpected", 32'd0, 32'd1);
        else void'(q.pop_front());
        if (q.size() > 0 && q[0].isHalt) begin
          hd = q.pop_front();
          chk("haltedAfterLast", 32'(halted), 32'd1);
          chk("haltPc", 32'(pc), 32'(hd.pcv));
          chk("haltNoValid", 32'(instrValid), 32'd0);
          chk("haltNoReq", 32'(imemReq), 32'd0);
        end
      end
      if (instrValid) begin
        if (q.size() == 0 || q[0].isHalt) begin
          chk("unexpectedInstr", 32'd0, 32'd1);
        end else begin
          hd = q[0];
          chk("opCode", 32'(opCode), 32'(hd.ins[8:6]));
          chk("destReg", 32'(destReg), 32'(hd.ins[5:3]));
          chk("srcReg", 32'(srcReg), 32'(hd.ins[2:0]));
          chk("issuePc", 32'(pc), 32'(hd.pcv));
          chk("issueNoReq", 32'(imemReq), 32'd0);
        end
      end
      if (imemReq && q.size() > 0 && !q[0].isHalt) begin
        chk("fetchAddr", 32'(imemAddr), 32'(q[0].pcv));
      end
    end
  end

  task automatic runProgram(input int lat, input int readyPct, input int jumpPct,
                            input int jumpAtAcc, input int jumpTo, input int maxCycles);
    int   mPc, nxt, accN, lastAcc, firstValid;
    bit   mDone;
    exp_t e;
    memLat = lat; mPc = 0; mDone = 0; accN = 0; lastAcc = -1; firstValid = -1;
    start = 1'b1;
    e.isHalt = 1'b0; e.pcv = 0; e.ins = mem[0];
    q.push_back(e);
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < maxCycles && !mDone; c++) begin
      instrReady = ($urandom_range(0, 99) < readyPct);
      jumpEn     = ($urandom_range(0, 99) < jumpPct);
      jumpAddr   = AW'($urandom_range(0, 15));
      if (instrValid && firstValid < 0) begin
        firstValid = c;
        chk("firstLatency", 32'(c), 32'(lat));
      end
      if (instrValid && instrReady) begin
        accN++;
        if (accN == jumpAtAcc) begin
          jumpEn   = 1'b1;
          jumpAddr = AW'(jumpTo);
        end
        if (readyPct == 100 && lastAcc >= 0) chk("issueSpacing", 32'(c - lastAcc), 32'(lat + 1));
        lastAcc = c;
        nxt = jumpEn ? int'(jumpAddr) : mPc + 1;
        if (nxt >= PL) begin
          e.isHalt = 1'b1; e.pcv = nxt % (1 << AW); e.ins = 9'd0;
          haltPcModel = e.pcv;
          mDone = 1'b1;
        end else begin
          e.isHalt = 1'b0; e.pcv = nxt; e.ins = mem[nxt];
          mPc = nxt;
        end
        q.push_back(e);
      end
      @(negedge clk);
    end
    instrReady = 1'b0;
    jumpEn     = 1'b0;
    chk("programHalts", 32'(mDone), 32'd1);
    repeat (2) @(negedge clk);
    chk("haltedHeld", 32'(halted), 32'd1);
    chk("pcHeld", 32'(pc), 32'(haltPcModel));
    chk("scoreboardDrained", 32'(q.size()), 32'd0);
    q.delete();
  endtask

  initial begin
    int wAcc, oAcc, wait_n;
    compared = 0; mismatched = 0; reqCnt = 0; memLat = 1; haltPcModel = 0;
    spurious = 1'b0; forceLate = 1'b0; scbOn = 1'b0;
    rst_n = 1'b0; start = 1'b0; instrReady = 1'b0; jumpEn = 1'b0; jumpAddr = '0;
    wStart = 1'b0; tieOne = 1'b1; tieZero = 1'b0; wJumpAddr = '0; oJumpAddr = '0;
    imemValid = 1'b0; imemData = 9'd0; wValid = 1'b0; wData = 9'd0; oValid = 1'b0; oData = 9'd0;
    for (int i = 0; i < 32; i++) mem[i] = 9'($urandom);
    repeat (3) @(negedge clk);
    chk("rstReq", 32'(imemReq), 32'd0);
    chk("rstValid", 32'(instrValid), 32'd0);
    chk("rstHalted", 32'(halted), 32'd0);
    chk("rstPc", 32'(pc), 32'd0);
    chk("rstOp", 32'({opCode, destReg, srcReg}), 32'd0);
    rst_n = 1'b1;
    scbOn = 1'b1;
    @(negedge clk);

    // directed program, then jump to PROG_LEN on the 4th accept
    mem[0] = 9'b010_001_010; mem[1] = 9'b011_011_001;
    mem[2] = 9'b111_000_001; mem[3] = 9'b000_010_000;
    runProgram(1, 100, 0, 4, PL, 200);
    // jump back to 0 at the accept of instruction 2, then run to the end
    runProgram(1, 100, 0, 2, 0, 200);
    // 3-cycle memory with stray responses
    spurious = 1'b1;
    runProgram(3, 100, 0, 0, 0, 400);
    // randomized programs, latencies, backpressure and jumps
    for (int ep = 0; ep < 12; ep++) begin
      for (int i = 0; i < 32; i++) mem[i] = 9'($urandom);
      runProgram($urandom_range(1, 4), $urandom_range(20, 100), $urandom_range(0, 30), 0, 0, 2000);
    end
    spurious = 1'b0;

    // end-of-program at 2^ADDR_W and single-instruction program
    wStart = 1'b1;
    @(negedge clk);
    wStart = 1'b0;
    wAcc = 0; oAcc = 0;
    for (int c = 0; c < 40; c++) begin
      if (wIV) wAcc++;
      if (oIV) oAcc++;
      @(negedge clk);
    end
    chk("wrapAccepts", 32'(wAcc), 32'd8);
    chk("wrapHalted", 32'(wHalted), 32'd1);
    chk("wrapNoReq", 32'(wReq), 32'd0);
    chk("wrapNoValid", 32'(wIV), 32'd0);
    chk("oneAccepts", 32'(oAcc), 32'd1);
    chk("oneHalted", 32'(oHalted), 32'd1);
    chk("onePc", 32'(oPc), 32'd1);
    wStart = 1'b1;
    @(negedge clk);
    wStart = 1'b0;
    chk("restartHaltedClr", 32'(wHalted), 32'd0);
    chk("restartAddr", 32'(wAddr), 32'd0);
    chk("restartReq", 32'(wReq), 32'd1);
    repeat (40) @(negedge clk);

    // async reset while an instruction is held in ISSUE
    scbOn = 1'b0; q.delete();
    memLat = 1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    instrReady = 1'b1;
    repeat (6) @(negedge clk);
    instrReady = 1'b0;
    wait_n = 0;
    while (!instrValid && wait_n < 10) begin
      @(negedge clk);
      wait_n++;
    end
    chk("issueReached", 32'(instrValid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rstIssueValid", 32'(instrValid), 32'd0);
    chk("rstIssuePc", 32'(pc), 32'd0);
    chk("rstIssueFields", 32'({opCode, destReg, srcReg}), 32'd0);
    chk("rstIssueHalted", 32'(halted), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // async reset mid-FETCH, then a late response after release
    memLat = 5;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("fetchReqBeforeRst", 32'(imemReq), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rstFetchReq", 32'(imemReq), 32'd0);
    chk("rstFetchAddr", 32'(imemAddr), 32'd0);
    chk("rstFetchValid", 32'(instrValid), 32'd0);
    forceLate = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("lateValidIgnored", 32'(instrValid), 32'd0);
    chk("lateNoReq", 32'(imemReq), 32'd0);
    chk("lateNotHalted", 32'(halted), 32'd0);
    forceLate = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
